// File: rtl/mem_copy_engine.sv
// Overlap-safe byte copy engine (memmove semantics) driving a single-port data memory.
// Each byte takes one READ cycle into a holding register and one WRITE cycle out of it.
module mem_copy_engine #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW-1:0] len,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_src_ptr;
   logic [AW-1:0] r_dst_ptr;
   logic [AW-1:0] r_cnt;
   logic [DW-1:0] r_hold;
   logic          r_desc;

   logic [AW-1:0] w_diff;
   logic          w_desc;
   logic [AW-1:0] w_len_m1;
   logic [AW-1:0] w_step;

   // Destination starting inside the source window would clobber unread bytes
   // when walking upward, so such copies run from the top end down.
   assign w_diff   = dst_addr - src_addr;
   assign w_desc   = (w_diff != '0) && (w_diff < len);
   assign w_len_m1 = len - ONE;
   assign w_step   = r_desc ? {AW{1'b1}} : ONE;

   assign mem_wdata = r_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_addr  = '0;
      mem_wr_en = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = (len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            mem_addr = r_src_ptr;
            w_next   = S_WRITE;
         end
         S_WRITE: begin
            mem_addr  = r_dst_ptr;
            mem_wr_en = 1'b1;
            w_next    = (r_cnt == ONE) ? S_DONE : S_READ;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_ptr <= '0;
         r_dst_ptr <= '0;
         r_cnt     <= '0;
         r_hold    <= '0;
         r_desc    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src_ptr <= w_desc ? (src_addr + w_len_m1) : src_addr;
                  r_dst_ptr <= w_desc ? (dst_addr + w_len_m1) : dst_addr;
                  r_cnt     <= len;
                  r_desc    <= w_desc;
               end
            end
            S_READ: begin
               r_hold <= mem_rdata;
            end
            S_WRITE: begin
               r_src_ptr <= r_src_ptr + w_step;
               r_dst_ptr <= r_dst_ptr + w_step;
               r_cnt     <= r_cnt - ONE;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
